// File: rtl/mem_stage_sized.sv
// mem_stage_sized: pipeline memory stage with byte/halfword/word access.
// Carries EX/MEM control and data through the data-memory access and registers
// the result into the MEM/WB boundary. Supports sign/zero-extended narrow loads,
// byte-enabled narrow stores, misalignment faults and configurable wait states.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ValidIn             instruction present in this stage
//   RegWrite, MemtoReg, MemRead, MemWrite, MemSize, MemUnsigned  EX control
//   WriteReg, ALUResult, WriteData                              EX data
//   Stall               combinational hold request to upstream
//   ValidOut, RegWriteOut, MemtoRegOut, WriteRegOut, ALUResultOut, MemOut,
//   Misalign            registered MEM/WB outputs
module mem_stage_sized #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidIn,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        ValidOut,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic [4:0]  WriteRegOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] MemOut,
  output logic        Misalign
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);
  localparam logic HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic        memto_reg_q, memto_reg_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] mem_out_q, mem_out_d;
  logic        misalign_q, misalign_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic              access_c;
  logic              fault_c;
  logic              stall_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] word_idx_c;
  logic [3:0]        byte_en_c;
  logic [31:0]       store_data_c;
  logic [31:0]       rd_word_c;
  logic [31:0]       rd_shift_c;
  logic [31:0]       load_data_c;

  // Address decode, fault detection and stall generation
  always_comb begin
    access_c   = ValidIn & (MemRead | MemWrite);
    word_idx_c = ALUResult[ADDR_W+1:2];
    case (MemSize)
      2'b00:   fault_c = 1'b0;
      2'b01:   fault_c = ALUResult[0];
      2'b10:   fault_c = (ALUResult[1:0] != 2'b00);
      default: fault_c = 1'b1;
    endcase
    fault_c = access_c & fault_c;
    // In WAIT the counter runs 1..WAIT_STATES; the last value is the completion cycle
    stall_c = HAS_WAIT & (((state_q == IDLE) & access_c) |
                          ((state_q == WAIT) & (cnt_q != WS_CNT)));
  end

  assign Stall = stall_c;

  // Store lane selection; data replicated so each lane sees its own bytes
  always_comb begin
    case (MemSize)
      2'b00: begin
        byte_en_c    = 4'b0001 << ALUResult[1:0];
        store_data_c = {4{WriteData[7:0]}};
      end
      2'b01: begin
        byte_en_c    = ALUResult[1] ? 4'b1100 : 4'b0011;
        store_data_c = {2{WriteData[15:0]}};
      end
      default: begin
        byte_en_c    = 4'b1111;
        store_data_c = WriteData;
      end
    endcase
    mem_we_c = access_c & MemWrite & ~fault_c & ~stall_c & ~rst;
  end

  // Load lane extraction and extension
  always_comb begin
    rd_word_c  = mem[word_idx_c];
    rd_shift_c = rd_word_c >> {ALUResult[1:0], 3'b000};
    case (MemSize)
      2'b00:   load_data_c = MemUnsigned ? {24'b0, rd_shift_c[7:0]}
                                         : {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
      2'b01:   load_data_c = MemUnsigned ? {16'b0, rd_shift_c[15:0]}
                                         : {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
      default: load_data_c = rd_word_c;
    endcase
  end

  // Wait-state sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access_c && HAS_WAIT) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q == WS_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next MEM/WB contents; stalled or invalid cycles load a bubble
  always_comb begin
    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    memto_reg_d  = 1'b0;
    write_reg_d  = '0;
    alu_result_d = '0;
    mem_out_d    = '0;
    misalign_d   = 1'b0;
    if (ValidIn && !stall_c) begin
      valid_d      = 1'b1;
      reg_write_d  = RegWrite & ~fault_c;
      memto_reg_d  = MemtoReg;
      write_reg_d  = WriteReg;
      alu_result_d = ALUResult;
      mem_out_d    = (access_c & MemRead & ~MemWrite & ~fault_c) ? load_data_c : '0;
      misalign_d   = fault_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      memto_reg_q  <= 1'b0;
      write_reg_q  <= '0;
      alu_result_q <= '0;
      mem_out_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      memto_reg_q  <= memto_reg_d;
      write_reg_q  <= write_reg_d;
      alu_result_q <= alu_result_d;
      mem_out_q    <= mem_out_d;
      misalign_q   <= misalign_d;
    end
  end

  // Data memory; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_c[i]) mem[word_idx_c][8*i +: 8] <= store_data_c[8*i +: 8];
      end
    end
  end

  assign ValidOut     = valid_q;
  assign RegWriteOut  = reg_write_q;
  assign MemtoRegOut  = memto_reg_q;
  assign WriteRegOut  = write_reg_q;
  assign ALUResultOut = alu_result_q;
  assign MemOut       = mem_out_q;
  assign Misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage_sized.sv
// Bench for mem_stage_sized: one instance with no wait states, one with three.
// A byte-level memory model predicts every output each cycle; directed
// sequences add literal expectations for key results.
module tb_mem_stage_sized;

  typedef struct packed {
    logic        valid, rw, m2r, mr, mw;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  wr;
    logic [31:0] alu, wd;
  } in_t;

  typedef struct packed {
    logic        v, rw, m2r;
    logic [4:0]  wr;
    logic [31:0] alu, mo;
    logic        mis;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  in_t  d0, d1;
  out_t o0, o1;
  logic st0, st1;

  logic        v0, rw0, m2r0, mis0, v1, rw1, m2r1, mis1;
  logic [4:0]  wr0, wr1;
  logic [31:0] alu0, mo0, alu1, mo1;

  assign o0 = {v0, rw0, m2r0, wr0, alu0, mo0, mis0};
  assign o1 = {v1, rw1, m2r1, wr1, alu1, mo1, mis1};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit stall_seen0 = 1'b0;

  mem_stage_sized #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst(rst0), .ValidIn(d0.valid), .RegWrite(d0.rw), .MemtoReg(d0.m2r),
    .MemRead(d0.mr), .MemWrite(d0.mw), .MemSize(d0.size), .MemUnsigned(d0.uns),
    .WriteReg(d0.wr), .ALUResult(d0.alu), .WriteData(d0.wd), .Stall(st0),
    .ValidOut(v0), .RegWriteOut(rw0), .MemtoRegOut(m2r0), .WriteRegOut(wr0),
    .ALUResultOut(alu0), .MemOut(mo0), .Misalign(mis0)
  );

  mem_stage_sized #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst(rst1), .ValidIn(d1.valid), .RegWrite(d1.rw), .MemtoReg(d1.m2r),
    .MemRead(d1.mr), .MemWrite(d1.mw), .MemSize(d1.size), .MemUnsigned(d1.uns),
    .WriteReg(d1.wr), .ALUResultOut(alu1), .ALUResult(d1.alu), .WriteData(d1.wd),
    .Stall(st1), .ValidOut(v1), .RegWriteOut(rw1), .MemtoRegOut(m2r1),
    .WriteRegOut(wr1), .MemOut(mo1), .Misalign(mis1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: byte-addressed memory, access completes after ws+1 cycles
  logic [7:0] mb [2][4096];
  bit         kn [2][4096];
  out_t       ex [2];
  bit         exok [2];
  int         age [2];

  task automatic model_step(input int k, input in_t i, input logic r, input int ws);
    logic        acc, flt;
    int          a, nb;
    logic [31:0] ld;
    bit          ok;
    if (r) begin
      ex[k] = '0; exok[k] = 1'b1; age[k] = 0;
      return;
    end
    acc = i.valid && (i.mr || i.mw);
    if (acc && age[k] < ws) begin
      age[k]++; ex[k] = '0; exok[k] = 1'b1;
      return;
    end
    age[k] = 0;
    if (!i.valid) begin
      ex[k] = '0; exok[k] = 1'b1;
      return;
    end
    case (i.size)
      2'd0:    flt = 1'b0;
      2'd1:    flt = i.alu[0];
      2'd2:    flt = (i.alu[1:0] != 2'd0);
      default: flt = 1'b1;
    endcase
    flt = acc && flt;
    a   = int'(i.alu[11:0]);
    nb  = (i.size == 2'd0) ? 1 : (i.size == 2'd1) ? 2 : 4;
    ld  = '0;
    ok  = 1'b1;
    if (acc && !flt && i.mr && !i.mw) begin
      for (int b = 0; b < nb; b++) begin
        ld = ld | (32'(mb[k][a+b]) << (8*b));
        ok = ok && kn[k][a+b];
      end
      if (i.size == 2'd0 && !i.uns && ld[7])  ld = ld | 32'hFFFF_FF00;
      if (i.size == 2'd1 && !i.uns && ld[15]) ld = ld | 32'hFFFF_0000;
    end
    if (acc && !flt && i.mw) begin
      for (int b = 0; b < nb; b++) begin
        mb[k][a+b] = i.wd[8*b +: 8];
        kn[k][a+b] = 1'b1;
      end
    end
    ex[k]   = '{v: 1'b1, rw: i.rw && !flt, m2r: i.m2r, wr: i.wr, alu: i.alu, mo: ld, mis: flt};
    exok[k] = ok;
  endtask

  always @(posedge clk) begin
    model_step(0, d0, rst0, 0);
    model_step(1, d1, rst1, 3);
  end

  // Per-cycle comparison against the model, plus input-hold check while stalled
  in_t  pin [2];
  bit   pst [2] = '{1'b0, 1'b0};
  bit   prst [2] = '{1'b0, 1'b0};

  task automatic cmp(input int k, input out_t o, input logic st, input in_t i,
                     input logic r, input int ws);
    logic es;
    string p;
    p  = $sformatf("w%0d", k);
    es = i.valid && (i.mr || i.mw) && (age[k] < ws);
    check({p, " stall"},  32'(st),    32'(es));
    check({p, " valid"},  32'(o.v),   32'(ex[k].v));
    check({p, " regwr"},  32'(o.rw),  32'(ex[k].rw));
    check({p, " m2r"},    32'(o.m2r), 32'(ex[k].m2r));
    check({p, " wreg"},   32'(o.wr),  32'(ex[k].wr));
    check({p, " alu"},    o.alu,      ex[k].alu);
    check({p, " misal"},  32'(o.mis), 32'(ex[k].mis));
    if (exok[k]) check({p, " memout"}, o.mo, ex[k].mo);
    if (pst[k] && !prst[k] && !r) check({p, " held_inputs"}, 32'(i != pin[k]), 32'd0);
    pin[k]  = i;
    pst[k]  = st;
    prst[k] = r;
    if (k == 0 && st) stall_seen0 = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, o0, st0, d0, rst0, 0);
      cmp(1, o1, st1, d1, rst1, 3);
    end
  end

  // Stimulus helpers
  function automatic in_t mk(input logic rd, input logic wrt, input logic [1:0] sz,
                             input logic un, input logic rw, input logic [31:0] a,
                             input logic [31:0] d);
    in_t t;
    t.valid = 1'b1; t.rw = rw; t.m2r = rd; t.mr = rd; t.mw = wrt;
    t.size = sz; t.uns = un; t.wr = 5'd7; t.alu = a; t.wd = d;
    return t;
  endfunction

  task automatic set_in(input int k, input in_t v);
    if (k == 0) d0 = v; else d1 = v;
  endtask

  // Present one instruction, hold it through the stall, return at edge+1
  task automatic op(input int k, input in_t v, output int stalls);
    int  n;
    bit  done;
    logic s;
    stalls = 0;
    done   = 1'b0;
    set_in(k, v);
    for (n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      s = (k == 0) ? st0 : st1;
      if (s) stalls++; else done = 1'b1;
    end
    if (!done) check("op_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    set_in(k, '0);
  endtask

  initial begin
    int s;
    rst0 = 1'b1; rst1 = 1'b1; d0 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    chk_en = 1'b1;
    check("rst w0 valid", 32'(v0), 32'd0);
    check("rst w0 memout", mo0, 32'd0);
    check("rst w3 valid", 32'(v1), 32'd0);
    check("rst w3 alu", alu1, 32'd0);

    // No wait states
    op(0, mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF), s);
    check("sw stalls", 32'(s), 32'd0);
    op(0, mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0), s);
    check("lw data", mo0, 32'hDEAD_BEEF);
    check("lw valid", 32'(v0), 32'd1);

    op(0, mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h13, 32'h0000_0080), s);
    op(0, mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h13, 32'h0), s);
    check("lb sign", mo0, 32'hFFFF_FF80);
    op(0, mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'h13, 32'h0), s);
    check("lbu zero", mo0, 32'h0000_0080);
    op(0, mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0), s);
    check("lw after sb", mo0, 32'h80AD_BEEF);

    op(0, mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h12, 32'h0000_1234), s);
    op(0, mk(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 32'h12, 32'h0), s);
    check("lh", mo0, 32'h0000_1234);
    op(0, mk(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h10, 32'h0), s);
    check("lhu low", mo0, 32'h0000_BEEF);

    op(0, mk(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 32'h11, 32'h0), s);
    check("lh misal flag", 32'(mis0), 32'd1);
    check("lh misal regwr", 32'(rw0), 32'd0);
    check("lh misal data", mo0, 32'd0);
    op(0, mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h11, 32'hFFFF_FFFF), s);
    check("sw misal flag", 32'(mis0), 32'd1);
    op(0, mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0), s);
    check("mem after bad sw", mo0, 32'h1234_BEEF);

    op(0, mk(1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 32'hABCD_0001, 32'h0), s);
    check("pass alu", alu0, 32'hABCD_0001);
    check("pass misal", 32'(mis0), 32'd0);
    check("pass regwr", 32'(rw0), 32'd1);

    op(0, mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h1010, 32'h0000_0055), s);
    op(0, mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0), s);
    check("alias lw", mo0, 32'h0000_0055);

    // Three wait states
    op(1, mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h20, 32'hCAFE_F00D), s);
    check("w3 sw stalls", 32'(s), 32'd3);
    op(1, mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h20, 32'h0), s);
    check("w3 lw stalls", 32'(s), 32'd3);
    check("w3 lw data", mo1, 32'hCAFE_F00D);

    begin
      in_t t;
      t = mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h20, 32'h0);
      t.valid = 1'b0;
      op(1, t, s);
      check("w3 invalid stalls", 32'(s), 32'd0);
      check("w3 invalid valid", 32'(v1), 32'd0);
    end

    // Reset during the second stall cycle of a store
    d1 = mk(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h20, 32'h1111_1111);
    @(negedge clk);
    check("w3 rst stall1", 32'(st1), 32'd1);
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    @(negedge clk);
    check("w3 rst stall2", 32'(st1), 32'd1);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    d1 = '0;
    check("w3 rst valid", 32'(v1), 32'd0);
    check("w3 rst alu", alu1, 32'd0);
    check("w3 rst misal", 32'(mis1), 32'd0);
    op(1, mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h20, 32'h0), s);
    check("w3 lw after rst stalls", 32'(s), 32'd3);
    check("w3 lw after rst", mo1, 32'hCAFE_F00D);
    op(1, mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h22, 32'h0), s);
    check("w3 misal stalls", 32'(s), 32'd3);
    check("w3 misal flag", 32'(mis1), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check("w0 never stalled", 32'(stall_seen0), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
